// File: rtl/jr_stall_ctrl_pkg.sv
// Shared pipeline definitions for jr hazard handling: forward-source and
// stall-controller state encodings, plus the register-match helper.
package jr_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_RF    = 2'b11
  } jr_fwd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } jr_state_e;

  // r0 is hardwired zero, so it never creates a dependency.
  function automatic logic rs_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/jr_stall_ctrl_src_mux.sv
// jr target source selection: picks the freshest copy of the jr source
// register during a resolve cycle, otherwise drives zeros.
module jr_src_mux
  import jr_stall_ctrl_pkg::*;
(
  input  logic        resolve,
  input  logic [4:0]  IFID_rs,
  input  logic        EXMEM_RegWrite,
  input  logic        EXMEM_MemRead,
  input  logic [4:0]  EXMEM_rd,
  input  logic        MEMWB_RegWrite,
  input  logic [4:0]  MEMWB_rd,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] exmem_alu_out,
  input  logic [31:0] memwb_wdata,
  output logic [1:0]  jr_forward,
  output logic [31:0] jr_target
);

  jr_fwd_e sel;

  always_comb begin
    sel       = FWD_NONE;
    jr_target = '0;
    if (resolve) begin
      if (EXMEM_RegWrite && !EXMEM_MemRead && rs_match(EXMEM_rd, IFID_rs)) begin
        sel       = FWD_EXMEM;
        jr_target = exmem_alu_out;
      end else if (MEMWB_RegWrite && rs_match(MEMWB_rd, IFID_rs)) begin
        sel       = FWD_MEMWB;
        jr_target = memwb_wdata;
      end else begin
        sel       = FWD_RF;
        jr_target = rf_rs_data;
      end
    end
  end

  assign jr_forward = sel;

endmodule

// File: rtl/jr_stall_ctrl.sv
// jr hazard controller: stalls IF/ID for exactly as many cycles as the jr
// source operand needs, then redirects the PC and flushes IF/ID.
module jr_stall_ctrl
  import jr_stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jrjump,
  input  logic [4:0]  IFID_rs,
  input  logic        IDEX_RegWrite,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_rd,
  input  logic        EXMEM_RegWrite,
  input  logic        EXMEM_MemRead,
  input  logic [4:0]  EXMEM_rd,
  input  logic        MEMWB_RegWrite,
  input  logic [4:0]  MEMWB_rd,
  input  logic        kill,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] exmem_alu_out,
  input  logic [31:0] memwb_wdata,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_bubble,
  output logic        jr_valid,
  output logic [31:0] jr_target,
  output logic        ifid_flush,
  output logic [1:0]  jr_forward
);

  jr_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] n_stall;
  logic       stall;
  logic       resolve;

  always_comb begin
    n_stall = 2'd0;
    if (IDEX_RegWrite && IDEX_MemRead && rs_match(IDEX_rd, IFID_rs))
      n_stall = 2'd2;
    else if (IDEX_RegWrite && rs_match(IDEX_rd, IFID_rs))
      n_stall = 2'd1;
    else if (EXMEM_MemRead && EXMEM_RegWrite && rs_match(EXMEM_rd, IFID_rs))
      n_stall = 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (jrjump && (n_stall != 2'd0)) begin
            state_d = ST_WAIT;
            cnt_d   = n_stall - 2'd1;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are gated by rst_n so a held reset shows idle values even
  // while jrjump and hazard inputs are still asserted.
  always_comb begin
    stall   = 1'b0;
    resolve = 1'b0;
    if (rst_n && !kill) begin
      case (state_q)
        ST_IDLE: begin
          if (jrjump) begin
            stall   = (n_stall != 2'd0);
            resolve = (n_stall == 2'd0);
          end
        end
        ST_WAIT: begin
          stall   = (cnt_q != 2'd0);
          resolve = (cnt_q == 2'd0);
        end
        default: ;
      endcase
    end
  end

  assign pc_stall    = stall;
  assign ifid_stall  = stall;
  assign idex_bubble = stall;
  assign jr_valid    = resolve;
  assign ifid_flush  = resolve;

  jr_src_mux u_src_mux (
    .resolve        (resolve),
    .IFID_rs        (IFID_rs),
    .EXMEM_RegWrite (EXMEM_RegWrite),
    .EXMEM_MemRead  (EXMEM_MemRead),
    .EXMEM_rd       (EXMEM_rd),
    .MEMWB_RegWrite (MEMWB_RegWrite),
    .MEMWB_rd       (MEMWB_rd),
    .rf_rs_data     (rf_rs_data),
    .exmem_alu_out  (exmem_alu_out),
    .memwb_wdata    (memwb_wdata),
    .jr_forward     (jr_forward),
    .jr_target      (jr_target)
  );

endmodule

// File: tb/tb_jr_stall_ctrl.sv
// Directed bench for jr_stall_ctrl: hand-computed expectations for hazard
// stalls, forwarding source selection, kill and reset behaviour.
module tb_jr_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic        jrjump;
  logic [4:0]  IFID_rs;
  logic        IDEX_RegWrite, IDEX_MemRead;
  logic [4:0]  IDEX_rd;
  logic        EXMEM_RegWrite, EXMEM_MemRead;
  logic [4:0]  EXMEM_rd;
  logic        MEMWB_RegWrite;
  logic [4:0]  MEMWB_rd;
  logic        kill;
  logic [31:0] rf_rs_data, exmem_alu_out, memwb_wdata;
  logic        pc_stall, ifid_stall, idex_bubble, jr_valid, ifid_flush;
  logic [31:0] jr_target;
  logic [1:0]  jr_forward;

  int unsigned checks;
  int unsigned failures;

  // {pc_stall, ifid_stall, idex_bubble, jr_valid, ifid_flush, jr_forward}
  logic [6:0] ctl;
  assign ctl = {pc_stall, ifid_stall, idex_bubble, jr_valid, ifid_flush, jr_forward};

  localparam logic [6:0] CTL_IDLE  = 7'b000_00_00;
  localparam logic [6:0] CTL_STALL = 7'b111_00_00;
  localparam logic [6:0] CTL_RF    = 7'b000_11_11;
  localparam logic [6:0] CTL_EXMEM = 7'b000_11_10;
  localparam logic [6:0] CTL_MEMWB = 7'b000_11_01;

  jr_stall_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jrjump         (jrjump),
    .IFID_rs        (IFID_rs),
    .IDEX_RegWrite  (IDEX_RegWrite),
    .IDEX_MemRead   (IDEX_MemRead),
    .IDEX_rd        (IDEX_rd),
    .EXMEM_RegWrite (EXMEM_RegWrite),
    .EXMEM_MemRead  (EXMEM_MemRead),
    .EXMEM_rd       (EXMEM_rd),
    .MEMWB_RegWrite (MEMWB_RegWrite),
    .MEMWB_rd       (MEMWB_rd),
    .kill           (kill),
    .rf_rs_data     (rf_rs_data),
    .exmem_alu_out  (exmem_alu_out),
    .memwb_wdata    (memwb_wdata),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .idex_bubble    (idex_bubble),
    .jr_valid       (jr_valid),
    .jr_target      (jr_target),
    .ifid_flush     (ifid_flush),
    .jr_forward     (jr_forward)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    jrjump = 0; IFID_rs = 0; kill = 0;
    IDEX_RegWrite = 0; IDEX_MemRead = 0; IDEX_rd = 0;
    EXMEM_RegWrite = 0; EXMEM_MemRead = 0; EXMEM_rd = 0;
    MEMWB_RegWrite = 0; MEMWB_rd = 0;
    rf_rs_data = 32'h0; exmem_alu_out = 32'h0; memwb_wdata = 32'h0;
  endtask

  // Advance one clock; inputs change 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    jrjump = 1; IFID_rs = 5; IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_rd = 5;
    rf_rs_data = 32'hDEAD_BEEF;
    step(); #1;
    if (ctl !== CTL_IDLE) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    checks++;
    if (jr_target !== 32'h0) begin failures++; $display("FAIL reset_target got=%h exp=%h", jr_target, 32'h0); end
    checks++;
    clear_inputs();
    step();
    rst_n = 1;
    step();
    if (ctl !== CTL_IDLE) begin failures++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    checks++;
  endtask

  task automatic test_jrjump_zero();
    clear_inputs();
    IFID_rs = 5; IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_rd = 5;
    EXMEM_RegWrite = 1; EXMEM_rd = 5; exmem_alu_out = 32'h55; rf_rs_data = 32'h66;
    #1;
    if (ctl !== CTL_IDLE) begin failures++; $display("FAIL nojr_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    checks++;
    if (jr_target !== 32'h0) begin failures++; $display("FAIL nojr_target got=%h exp=%h", jr_target, 32'h0); end
    checks++;
    step();
    clear_inputs();
  endtask

  task automatic test_no_hazard();
    clear_inputs();
    jrjump = 1; IFID_rs = 5; rf_rs_data = 32'h100;
    IDEX_RegWrite = 1; IDEX_rd = 6; MEMWB_RegWrite = 1; MEMWB_rd = 7;
    #1;
    if (ctl !== CTL_RF) begin failures++; $display("FAIL nohaz_ctl got=%b exp=%b", ctl, CTL_RF); end
    checks++;
    if (jr_target !== 32'h100) begin failures++; $display("FAIL nohaz_target got=%h exp=%h", jr_target, 32'h100); end
    checks++;
    step();
    clear_inputs();
  endtask

  task automatic test_alu_in_ex();
    clear_inputs();
    jrjump = 1; IFID_rs = 5; rf_rs_data = 32'h999;
    IDEX_RegWrite = 1; IDEX_rd = 5;
    #1;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL alu_stall_ctl got=%b exp=%b", ctl, CTL_STALL); end
    checks++;
    if (jr_target !== 32'h0) begin failures++; $display("FAIL alu_stall_target got=%h exp=%h", jr_target, 32'h0); end
    checks++;
    step();
    IDEX_RegWrite = 0; IDEX_rd = 0;
    EXMEM_RegWrite = 1; EXMEM_rd = 5; exmem_alu_out = 32'h200;
    #1;
    if (ctl !== CTL_EXMEM) begin failures++; $display("FAIL alu_resolve_ctl got=%b exp=%b", ctl, CTL_EXMEM); end
    checks++;
    if (jr_target !== 32'h200) begin failures++; $display("FAIL alu_resolve_target got=%h exp=%h", jr_target, 32'h200); end
    checks++;
    step();
    clear_inputs();
    #1;
    if (ctl !== CTL_IDLE) begin failures++; $display("FAIL alu_after_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    checks++;
  endtask

  task automatic test_load_in_ex();
    clear_inputs();
    jrjump = 1; IFID_rs = 5; rf_rs_data = 32'h999;
    IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_rd = 5;
    #1;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL load_stall1_ctl got=%b exp=%b", ctl, CTL_STALL); end
    checks++;
    step();
    IDEX_RegWrite = 0; IDEX_MemRead = 0; IDEX_rd = 0;
    EXMEM_RegWrite = 1; EXMEM_MemRead = 1; EXMEM_rd = 5; exmem_alu_out = 32'h444;
    #1;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL load_stall2_ctl got=%b exp=%b", ctl, CTL_STALL); end
    checks++;
    step();
    EXMEM_RegWrite = 0; EXMEM_MemRead = 0; EXMEM_rd = 0;
    MEMWB_RegWrite = 1; MEMWB_rd = 5; memwb_wdata = 32'h300;
    #1;
    if (ctl !== CTL_MEMWB) begin failures++; $display("FAIL load_resolve_ctl got=%b exp=%b", ctl, CTL_MEMWB); end
    checks++;
    if (jr_target !== 32'h300) begin failures++; $display("FAIL load_resolve_target got=%h exp=%h", jr_target, 32'h300); end
    checks++;
    step();
    clear_inputs();
  endtask

  task automatic test_load_in_mem();
    clear_inputs();
    jrjump = 1; IFID_rs = 9; rf_rs_data = 32'h1;
    EXMEM_RegWrite = 1; EXMEM_MemRead = 1; EXMEM_rd = 9;
    #1;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL memload_stall_ctl got=%b exp=%b", ctl, CTL_STALL); end
    checks++;
    step();
    EXMEM_RegWrite = 0; EXMEM_MemRead = 0; EXMEM_rd = 0;
    MEMWB_RegWrite = 1; MEMWB_rd = 9; memwb_wdata = 32'hABCD_0004;
    #1;
    if (ctl !== CTL_MEMWB) begin failures++; $display("FAIL memload_resolve_ctl got=%b exp=%b", ctl, CTL_MEMWB); end
    checks++;
    if (jr_target !== 32'hABCD_0004) begin failures++; $display("FAIL memload_target got=%h exp=%h", jr_target, 32'hABCD_0004); end
    checks++;
    step();
    clear_inputs();
  endtask

  task automatic test_priority();
    clear_inputs();
    jrjump = 1; IFID_rs = 12; rf_rs_data = 32'h11;
    EXMEM_RegWrite = 1; EXMEM_rd = 12; exmem_alu_out = 32'h22;
    MEMWB_RegWrite = 1; MEMWB_rd = 12; memwb_wdata = 32'h33;
    #1;
    if (ctl !== CTL_EXMEM) begin failures++; $display("FAIL prio_ctl got=%b exp=%b", ctl, CTL_EXMEM); end
    checks++;
    if (jr_target !== 32'h22) begin failures++; $display("FAIL prio_target got=%h exp=%h", jr_target, 32'h22); end
    checks++;
    step();
  endtask

  task automatic test_rs_zero();
    clear_inputs();
    jrjump = 1; IFID_rs = 0; rf_rs_data = 32'h1234;
    IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_rd = 0;
    EXMEM_RegWrite = 1; EXMEM_rd = 0; exmem_alu_out = 32'h77;
    MEMWB_RegWrite = 1; MEMWB_rd = 0; memwb_wdata = 32'h88;
    #1;
    if (ctl !== CTL_RF) begin failures++; $display("FAIL rs0_ctl got=%b exp=%b", ctl, CTL_RF); end
    checks++;
    if (jr_target !== 32'h1234) begin failures++; $display("FAIL rs0_target got=%h exp=%h", jr_target, 32'h1234); end
    checks++;
    step();
    clear_inputs();
  endtask

  task automatic test_kill();
    clear_inputs();
    jrjump = 1; IFID_rs = 5; rf_rs_data = 32'h5;
    IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_rd = 5;
    step();
    IDEX_RegWrite = 0; IDEX_MemRead = 0; IDEX_rd = 0;
    EXMEM_RegWrite = 1; EXMEM_MemRead = 1; EXMEM_rd = 5;
    kill = 1;
    #1;
    if (ctl !== CTL_IDLE) begin failures++; $display("FAIL kill_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    checks++;
    step();
    clear_inputs();
    #1;
    if (ctl !== CTL_IDLE) begin failures++; $display("FAIL kill_after_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    checks++;
    // An ALU hazard stalls only from IDLE; a stale WAIT would resolve instead.
    jrjump = 1; IFID_rs = 3; IDEX_RegWrite = 1; IDEX_rd = 3;
    #1;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL kill_idle_probe got=%b exp=%b", ctl, CTL_STALL); end
    checks++;
    step();
    clear_inputs();
    jrjump = 1; IFID_rs = 3; rf_rs_data = 32'h3;
    #1;
    if (ctl !== CTL_RF) begin failures++; $display("FAIL kill_probe_resolve got=%b exp=%b", ctl, CTL_RF); end
    checks++;
    step();
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    clear_inputs();
    jrjump = 1; IFID_rs = 5;
    IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_rd = 5;
    step();
    IDEX_RegWrite = 0; IDEX_MemRead = 0; IDEX_rd = 0;
    #1;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL rstwait_pre_ctl got=%b exp=%b", ctl, CTL_STALL); end
    checks++;
    rst_n = 0;
    #1;
    if (ctl !== CTL_IDLE) begin failures++; $display("FAIL rstwait_assert_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    checks++;
    step();
    clear_inputs();
    rst_n = 1;
    #1;
    if (ctl !== CTL_IDLE) begin failures++; $display("FAIL rstwait_release_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    checks++;
    step();
    if (ctl !== CTL_IDLE) begin failures++; $display("FAIL rstwait_release2_ctl got=%b exp=%b", ctl, CTL_IDLE); end
    checks++;
    jrjump = 1; IFID_rs = 4; IDEX_RegWrite = 1; IDEX_rd = 4;
    #1;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL rstwait_idle_probe got=%b exp=%b", ctl, CTL_STALL); end
    checks++;
    step();
    clear_inputs();
    jrjump = 1; IFID_rs = 4;
    step();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    jrjump = 1; IFID_rs = 8; rf_rs_data = 32'h800;
    #1;
    if (ctl !== CTL_RF) begin failures++; $display("FAIL b2b_first_ctl got=%b exp=%b", ctl, CTL_RF); end
    checks++;
    step();
    IDEX_RegWrite = 1; IDEX_rd = 8;
    #1;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL b2b_second_ctl got=%b exp=%b", ctl, CTL_STALL); end
    checks++;
    step();
    IDEX_RegWrite = 0; IDEX_rd = 0;
    EXMEM_RegWrite = 1; EXMEM_rd = 8; exmem_alu_out = 32'h880;
    #1;
    if (jr_target !== 32'h880) begin failures++; $display("FAIL b2b_second_target got=%h exp=%h", jr_target, 32'h880); end
    checks++;
    step();
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    rst_n = 1;
    test_reset();
    test_jrjump_zero();
    test_no_hazard();
    test_alu_in_ex();
    test_load_in_ex();
    test_load_in_mem();
    test_priority();
    test_rs_zero();
    test_kill();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
